// File: rtl/ppu_data_port.sv
// ppu_data_port: CPU-side PPUADDR/PPUDATA/PPUSCROLL port that owns the 14-bit VRAM address v.
// Latency: a register strobe is captured on clk_en edge N. A $2007 access runs during clk_en cycle N+1
//          and commits, with the increment of v, at that cycle's closing edge.
// Backpressure: none. A strobe is accepted on every clk_en edge, including the edge that closes an access.
//
// Ports:
//   clk, rst_n                       master clock, asynchronous active-low reset
//   clk_en                           PPU clock enable; state advances only on clk edges with clk_en=1
//   reg_en/reg_sel/reg_rw/reg_wdata  CPU register strobe ($2000+reg_sel)
//   reg_rdata                        registered PPUDATA read result
//   inc32, mirror_v                  PPUCTRL increment select, nametable mirroring select
//   vram_*                           nametable RAM port (11-bit mirrored address)
//   chr_addr/chr_rdata               CHR ROM read port
//   pal_*                            palette RAM port
//   scroll_x, scroll_y               last PPUSCROLL values
module ppu_data_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        reg_en,
  input  logic [2:0]  reg_sel,
  input  logic        reg_rw,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic        inc32,
  input  logic        mirror_v,
  output logic [10:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_rdata,
  output logic [4:0]  pal_addr,
  output logic        pal_we,
  output logic [7:0]  pal_wdata,
  input  logic [7:0]  pal_rdata,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [13:0] r_v;
  logic [5:0]  r_t_hi;
  logic        r_w;
  logic [7:0]  r_rbuf;
  logic [7:0]  r_wdat;
  logic [7:0]  r_rdata;
  logic [7:0]  r_scroll_x;
  logic [7:0]  r_scroll_y;

  // Strobe decode; every action is qualified by clk_en.
  logic w_acc;
  logic w_wr7, w_rd7;
  assign w_acc = clk_en & reg_en;
  assign w_wr7 = w_acc & (reg_sel == 3'd7) & ~reg_rw;
  assign w_rd7 = w_acc & (reg_sel == 3'd7) &  reg_rw;

  // Target decode of v.
  logic w_tgt_chr, w_tgt_pal, w_tgt_vram;
  assign w_tgt_chr  = ~r_v[13];
  assign w_tgt_pal  = (r_v[13:8] == 6'h3F);
  assign w_tgt_vram = r_v[13] & ~w_tgt_pal;

  logic [13:0] w_v_inc;
  assign w_v_inc = r_v + (inc32 ? 14'd32 : 14'd1);

  // Address outputs are always live from v. A palette read refills rbuf from the
  // nametable at v-$1000; that only changes bits 13:12, so the decode of v is used as is.
  assign chr_addr  = r_v[12:0];
  assign vram_addr = mirror_v ? {r_v[10], r_v[9:0]} : {r_v[11], r_v[9:0]};
  // $3F10/14/18/1C alias the background entries $3F00/04/08/0C.
  assign pal_addr  = (r_v[1:0] == 2'b00) ? {1'b0, r_v[3:0]} : r_v[4:0];

  assign vram_wdata = r_wdat;
  assign pal_wdata  = r_wdat;
  assign reg_rdata  = r_rdata;
  assign scroll_x   = r_scroll_x;
  assign scroll_y   = r_scroll_y;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. A new $2007 strobe may arrive on the edge that closes an access.
  always_comb begin
    w_state_nxt = r_state;
    if (clk_en) begin
      if (w_wr7) begin
        w_state_nxt = S_WR;
      end else if (w_rd7) begin
        w_state_nxt = S_RD;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // FSM: outputs. Write enables come straight from state, so they hold while clk_en is low
  // and drop the moment reset clears the state. CHR writes are dropped: CHR is ROM.
  always_comb begin
    vram_we = 1'b0;
    pal_we  = 1'b0;
    if (r_state == S_WR) begin
      vram_we = w_tgt_vram;
      pal_we  = w_tgt_pal;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v        <= 14'd0;
      r_t_hi     <= 6'd0;
      r_w        <= 1'b0;
      r_rbuf     <= 8'd0;
      r_wdat     <= 8'd0;
      r_rdata    <= 8'd0;
      r_scroll_x <= 8'd0;
      r_scroll_y <= 8'd0;
    end else if (clk_en) begin
      // Completing access: advance v and refill the read buffer.
      if (r_state != S_IDLE) begin
        r_v <= w_v_inc;
      end
      if (r_state == S_RD) begin
        r_rbuf <= w_tgt_chr ? chr_rdata : vram_rdata;
      end
      // New strobe. It is placed after the increment so that the second
      // $2006 write wins over an increment on the same edge.
      if (reg_en) begin
        case (reg_sel)
          3'd2: begin
            if (reg_rw) begin
              r_w <= 1'b0;
            end
          end
          3'd5: begin
            if (!reg_rw) begin
              if (!r_w) begin
                r_scroll_x <= reg_wdata;
              end else begin
                r_scroll_y <= reg_wdata;
              end
              r_w <= ~r_w;
            end
          end
          3'd6: begin
            if (!reg_rw) begin
              if (!r_w) begin
                r_t_hi <= reg_wdata[5:0];
              end else begin
                r_v <= {r_t_hi, reg_wdata};
              end
              r_w <= ~r_w;
            end
          end
          3'd7: begin
            if (reg_rw) begin
              // Palette reads bypass the buffer and return immediately.
              r_rdata <= w_tgt_pal ? pal_rdata : r_rbuf;
            end else begin
              r_wdat <= reg_wdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_data_port.sv
module tb_ppu_data_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        reg_en = 1'b0;
  logic [2:0]  reg_sel = 3'd0;
  logic        reg_rw = 1'b0;
  logic [7:0]  reg_wdata = 8'd0;
  logic [7:0]  reg_rdata;
  logic        inc32 = 1'b0;
  logic        mirror_v = 1'b0;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [12:0] chr_addr;
  logic [7:0]  chr_rdata;
  logic [4:0]  pal_addr;
  logic        pal_we;
  logic [7:0]  pal_wdata;
  logic [7:0]  pal_rdata;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;

  ppu_data_port dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .reg_en(reg_en), .reg_sel(reg_sel), .reg_rw(reg_rw), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .inc32(inc32), .mirror_v(mirror_v),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .chr_addr(chr_addr), .chr_rdata(chr_rdata),
    .pal_addr(pal_addr), .pal_we(pal_we), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata),
    .scroll_x(scroll_x), .scroll_y(scroll_y)
  );

  always #5 clk = ~clk;

  // Environment memories seen by the DUT.
  logic [7:0] env_nt  [2048];
  logic [7:0] env_pal [32];
  logic [7:0] chr_rom [8192];

  assign vram_rdata = env_nt[vram_addr];
  assign pal_rdata  = env_pal[pal_addr];
  assign chr_rdata  = chr_rom[chr_addr];

  always @(posedge clk) begin
    if (clk_en && vram_we) env_nt[vram_addr] = vram_wdata;
    if (clk_en && pal_we)  env_pal[pal_addr] = pal_wdata;
  end

  // Reference model state.
  int         m_v, m_w, m_thi, m_rbuf, m_rd, m_sx, m_sy, m_wdat;
  logic [7:0] ref_nt  [2048];
  logic [7:0] ref_pal [32];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Nametable: 4 logical 1 KiB tables over 2 KiB; vertical keeps table%2, horizontal table/2.
  function automatic int nt_index(input int v, input bit mv);
    int i, tbl, off;
    i   = v % 'h1000;
    tbl = i / 'h400;
    off = i % 'h400;
    return mv ? (tbl % 2) * 'h400 + off : (tbl / 2) * 'h400 + off;
  endfunction

  function automatic int pal_index(input int v);
    int p;
    p = v % 32;
    if (p % 4 == 0) p = p % 16;
    return p;
  endfunction

  task automatic model_reset();
    m_v = 0; m_w = 0; m_thi = 0; m_rbuf = 0; m_rd = 0; m_sx = 0; m_sy = 0; m_wdat = 0;
  endtask

  task automatic check_addr(input string tag);
    if (m_v < 'h2000) begin
      chk({tag, "_chr_addr"}, chr_addr, m_v);
    end else begin
      chk({tag, "_vram_addr"}, vram_addr, nt_index(m_v, mirror_v));
      if (m_v >= 'h3F00) chk({tag, "_pal_addr"}, pal_addr, pal_index(m_v));
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rdata"}, reg_rdata, m_rd);
    chk({tag, "_scroll_x"}, scroll_x, m_sx);
    chk({tag, "_scroll_y"}, scroll_y, m_sy);
    chk({tag, "_vram_we"}, vram_we, 0);
    chk({tag, "_pal_we"}, pal_we, 0);
    check_addr(tag);
  endtask

  task automatic idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // One clk_en edge with the given strobe on the bus; returns at the following negedge.
  task automatic edge_with(input bit en, input int sel, input bit rw, input int data);
    @(negedge clk);
    reg_en = en; reg_sel = sel[2:0]; reg_rw = rw; reg_wdata = data[7:0]; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0; reg_en = 1'b0;
  endtask

  // Strobe-edge effect on the model; returns 1 for write access, 2 for read access, 0 otherwise.
  function automatic int model_strobe(input int sel, input bit rw, input int data);
    int pend;
    pend = 0;
    if (sel == 2 && rw) m_w = 0;
    else if (sel == 5 && !rw) begin
      if (m_w == 0) m_sx = data; else m_sy = data;
      m_w ^= 1;
    end else if (sel == 6 && !rw) begin
      if (m_w == 0) m_thi = data % 64; else m_v = m_thi * 256 + data;
      m_w ^= 1;
    end else if (sel == 7 && !rw) begin
      m_wdat = data; pend = 1;
    end else if (sel == 7 && rw) begin
      m_rd = (m_v < 'h3F00) ? m_rbuf : int'(ref_pal[pal_index(m_v)]);
      pend = 2;
    end
    return pend;
  endfunction

  task automatic model_complete(input int pend);
    if (pend == 1) begin
      if (m_v >= 'h3F00) ref_pal[pal_index(m_v)] = m_wdat[7:0];
      else if (m_v >= 'h2000) ref_nt[nt_index(m_v, mirror_v)] = m_wdat[7:0];
    end else begin
      m_rbuf = (m_v < 'h2000) ? int'(chr_rom[m_v]) : int'(ref_nt[nt_index(m_v, mirror_v)]);
    end
    m_v = (m_v + (inc32 ? 32 : 1)) % 'h4000;
  endtask

  task automatic exec_check(input string tag, input int pend);
    bit ev, ep;
    ev = (pend == 1) && m_v >= 'h2000 && m_v < 'h3F00;
    ep = (pend == 1) && m_v >= 'h3F00;
    chk({tag, "_x_vram_we"}, vram_we, ev);
    chk({tag, "_x_pal_we"}, pal_we, ep);
    if (ev) chk({tag, "_x_vram_wdata"}, vram_wdata, m_wdat);
    if (ep) chk({tag, "_x_pal_wdata"}, pal_wdata, m_wdat);
    check_addr({tag, "_x"});
  endtask

  task automatic op(input string tag, input int sel, input bit rw, input int data);
    int pend;
    edge_with(1'b1, sel, rw, data);
    pend = model_strobe(sel, rw, data);
    idle();
    if (pend != 0) begin
      exec_check(tag, pend);
      edge_with(1'b0, 0, 1'b0, 0);
      model_complete(pend);
      idle();
    end
    check_state(tag);
  endtask

  task automatic set_v(input int v);
    op("set_hi", 6, 1'b0, v / 256);
    op("set_lo", 6, 1'b0, v % 256);
  endtask

  initial begin
    int r, bad, pend;
    for (int i = 0; i < 2048; i++) begin r = $urandom; env_nt[i] = r[7:0]; ref_nt[i] = r[7:0]; end
    for (int i = 0; i < 32; i++) begin r = $urandom; env_pal[i] = r[7:0]; ref_pal[i] = r[7:0]; end
    for (int i = 0; i < 8192; i++) begin r = $urandom; chr_rom[i] = r[7:0]; end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_rdata", reg_rdata, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_chr_addr", chr_addr, 0);
    chk("rst_pal_addr", pal_addr, 0);
    chk("rst_we", {vram_we, pal_we}, 0);
    chk("rst_scroll", {scroll_x, scroll_y}, 0);

    // Buffered read: first read returns the reset buffer.
    inc32 = 1'b0; mirror_v = 1'b1;
    set_v('h2005);
    op("bw", 7, 1'b0, 'h5A);
    set_v('h2005);
    op("br1", 7, 1'b1, 0);
    chk("bufrd_first", reg_rdata, 0);
    op("br2", 7, 1'b1, 0);
    chk("bufrd_second", reg_rdata, 'h5A);
    chk("bufrd_v", vram_addr, 'h007);

    // Basic write with vertical mirroring.
    set_v('h2108);
    op("w108", 7, 1'b0, 'hAB);
    chk("w108_v", vram_addr, 'h109);

    // Increment by 32 and horizontal mirroring.
    inc32 = 1'b1;
    set_v('h2000);
    for (int i = 0; i < 3; i++) op("inc32", 7, 1'b0, 'h30 + i);
    mirror_v = 1'b0;
    set_v('h2400); op("h2400", 7, 1'b0, 'h11);
    set_v('h2800); op("h2800", 7, 1'b0, 'h22);
    inc32 = 1'b0;

    // Palette alias write and immediate read.
    set_v('h3F10); op("pal10", 7, 1'b0, 'h0F);
    set_v('h3F00); op("pal00", 7, 1'b1, 0);
    chk("pal_read_direct", reg_rdata, 'h0F);

    // Shared write toggle and scroll.
    op("tg1", 6, 1'b0, 'h3F); op("tg2", 2, 1'b1, 0);
    op("tg3", 6, 1'b0, 'h21); op("tg4", 6, 1'b0, 'h00);
    chk("toggle_v", vram_addr, 'h100);
    op("sx", 5, 1'b0, 'h10); op("sy", 5, 1'b0, 'h20);
    chk("scroll_xy", {scroll_x, scroll_y}, 'h1020);

    // CHR write dropped; wrap at $3FFF.
    set_v('h1000); op("chrw", 7, 1'b0, 'hEE);
    chk("chrw_v", chr_addr, 'h1001);
    set_v('h3FFF); op("wrap", 7, 1'b0, 'h05);
    chk("wrap_v", chr_addr, 0);

    // Second $2006 write on the closing edge of a write overrides the increment.
    mirror_v = 1'b1;
    set_v('h2340);
    op("ov_hi", 6, 1'b0, 'h25);
    edge_with(1'b1, 7, 1'b0, 'h77);
    pend = model_strobe(7, 1'b0, 'h77);
    exec_check("ov", pend);
    edge_with(1'b1, 6, 1'b0, 'h80);
    model_complete(pend);
    pend = model_strobe(6, 1'b0, 'h80);
    check_state("ov_done");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      inc32 = $urandom_range(0, 1);
      mirror_v = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      if (r < 15) begin
        case ($urandom_range(0, 2))
          0: set_v($urandom_range(0, 'h3FFF));
          1: set_v('h3F00 + $urandom_range(0, 255));
          default: set_v('h2000 + $urandom_range(0, 'h1EFF));
        endcase
      end else if (r < 45) op("rnd_w7", 7, 1'b0, $urandom_range(0, 255));
      else if (r < 75) op("rnd_r7", 7, 1'b1, 0);
      else if (r < 83) op("rnd_w5", 5, 1'b0, $urandom_range(0, 255));
      else if (r < 88) op("rnd_r2", 2, 1'b1, 0);
      else op("rnd_other", $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    end

    // Reset in the middle of a write: enable drops without a clock edge.
    mirror_v = 1'b1;
    set_v('h2010);
    edge_with(1'b1, 7, 1'b0, 'hCC);
    chk("rstmid_we_before", vram_we, 1);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_we_async", vram_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_state("rstmid");

    // Memory contents written through the port.
    bad = 0;
    for (int i = 0; i < 2048; i++) if (env_nt[i] !== ref_nt[i]) bad++;
    chk("nt_contents", bad, 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (env_pal[i] !== ref_pal[i]) bad++;
    chk("pal_contents", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ppu_data_port.md
# ppu_data_port

CPU-side PPU data port (PPUADDR $2006 / PPUDATA $2007) that owns the VRAM address register and drives the nametable VRAM's write/read port on behalf of the CPU. It implements the shared write toggle, the buffered PPUDATA read, the 1/32 address increment, nametable mirroring onto the 11-bit VRAM address, and routing to the CHR and palette ports. It also captures PPUSCROLL ($2005) writes. It sits between the CPU register decoder and the `vram` / palette / CHR memories in the PPU.

## Interface
- No parameters.
- clk  in  1  master clock
- rst_n  in  1  reset: asynchronous, active-low
- clk_en  in  1  PPU clock enable (master/4); all state advances only on clk edges with clk_en=1
- reg_en  in  1  CPU register access strobe, qualified by clk_en
- reg_sel  in  3  register index (0..7 = $2000..$2007)
- reg_rw  in  1  1=read, 0=write
- reg_wdata  in  8  CPU write data
- reg_rdata  out  8  PPUDATA read result (registered)
- inc32  in  1  PPUCTRL bit 2: address increment 32 (1) or 1 (0)
- mirror_v  in  1  1=vertical mirroring, 0=horizontal
- vram_addr  out  11  VRAM address
- vram_we  out  1  VRAM write enable
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data (combinational from vram_addr)
- chr_addr  out  13  CHR address
- chr_rdata  in  8  CHR read data (combinational)
- pal_addr  out  5  palette address
- pal_we  out  1  palette write enable
- pal_wdata  out  8  palette write data
- pal_rdata  in  8  palette read data (combinational)
- scroll_x, scroll_y  out  8 each  last PPUSCROLL values

## Operation
- State: v[13:0] (VRAM address), t_hi[5:0] (PPUADDR high latch), w (write toggle), rbuf[7:0], wdat[7:0], FSM {IDLE, WR, RD}.
- Reg 2 read: w<=0. All other reg 2 behaviour is outside this block.
- Reg 5 write: w=0 -> scroll_x<=data, w<=1; w=1 -> scroll_y<=data, w<=0.
- Reg 6 write: w=0 -> t_hi<=data[5:0] (bits 7:6 dropped), w<=1; w=1 -> v<={t_hi,data}, w<=0.
- Reg 7 write: wdat<=data, FSM->WR.
- Reg 7 read: FSM->RD. Source of reg_rdata depends on v:
  - v<$3F00: reg_rdata<=rbuf.
  - v>=$3F00: reg_rdata<=pal_rdata.
- Other reg/rw combinations: ignored.
- Address decode of v (14-bit):
  - $0000-$1FFF -> CHR, chr_addr=v[12:0].
  - $2000-$3EFF -> VRAM. Vertical mirroring: vram_addr={v[10],v[9:0]}. Horizontal: vram_addr={v[11],v[9:0]}. $3xxx mirrors $2xxx.
  - $3F00-$3FFF -> palette. pal_addr=v[4:0], except when v[1:0]=0, where pal_addr={1'b0,v[3:0]} ($3F10/14/18/1C alias $3F00/04/08/0C).
- WR (one clk_en cycle):
  - VRAM target: vram_we=1, vram_wdata=wdat.
  - Palette target: pal_we=1, pal_wdata=wdat.
  - CHR target: write dropped, since CHR is ROM.
  - Then v<=v+(inc32?32:1) mod $4000; FSM->IDLE.
- RD (one clk_en cycle):
  - rbuf<=chr_rdata for CHR targets, vram_rdata for VRAM targets.
  - Palette target: rbuf<=VRAM data at the nametable address mirrored underneath (v-$1000, i.e. $2F00-$2FFF decode).
  - Then increment v as in WR; FSM->IDLE.
- vram_addr, chr_addr and pal_addr are combinational from v at all times. In RD with a palette target, vram_addr uses the v-$1000 decode.

## Timing
- Reset values: v=0, t_hi=0, w=0, rbuf=0, wdat=0, reg_rdata=0, scroll_x=scroll_y=0, FSM=IDLE, vram_we=pal_we=0.
- Strobe accepted on clk_en edge N. The access executes in clk_en cycle N+1: we asserted during that cycle, write committed at its closing edge. v increments at the same edge.
- reg_rdata is valid from edge N and holds until the next reg 7 read.
- A strobe arriving in the WR/RD cycle is captured at that same edge. The current access completes and increments v first; a reg 6 write at that edge overrides the increment.
- vram_we and pal_we are asserted only in WR and are never asserted together.
- clk_en=0: all state holds and we outputs remain at their current level.
- Reset mid-access: the access is aborted, we is deasserted immediately, and v is cleared.
- v wraps from $3FFF to $0000 (or $3FE0+32 -> $0000 mod $4000).

## Test plan
- Reset -> all outputs 0; write $2006=$21, $2006=$08, $2007=$AB, mirror_v=1 -> vram_we one cycle, vram_addr=$108, data $AB; v=$2109.
- inc32=1, three $2007 writes from $2000 -> vram_addr $000,$020,$040; mirror_v=0 from $2400 -> vram_addr $000 (aliases $2000), from $2800 -> $400.
- Buffered read: VRAM[$005]=$5A, set v=$2005, read $2007 twice -> first reg_rdata=old rbuf (0 after reset), second=$5A; v=$2007.
- Palette: write $3F10=$0F -> pal_addr=$00, pal_we=1; read at $3F00 -> reg_rdata=$0F immediately; rbuf=VRAM at $2F00 decode.
- Toggle: $2006=$3F, read $2002, $2006=$21, $2006=$00 -> v=$2100; $2005=$10,$2005=$20 -> scroll_x=$10, scroll_y=$20.
- CHR write at $1000 -> no vram_we/pal_we, v=$1001; $3FFF+1 wraps to $0000; rst_n low during WR -> vram_we drops asynchronously.
